// File: rtl/host_key_decoder.sv
// rtl/host_key_decoder.sv - PS/2 set-2 scan-code decoder producing held-key movement levels
module host_key_decoder #(
  parameter logic [7:0] KEY_LEFT  = 8'h1C,
  parameter logic [7:0] KEY_RIGHT = 8'h23,
  parameter logic [7:0] KEY_JUMP  = 8'h1D,
  parameter logic [7:0] KEY_RESET = 8'h2D,
  parameter logic [7:0] EXT_LEFT  = 8'h6B,
  parameter logic [7:0] EXT_RIGHT = 8'h74,
  parameter logic [7:0] EXT_JUMP  = 8'h75
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] key_code,
  input  logic       key_valid,
  output logic       left,
  output logic       right,
  output logic       jump,
  output logic       reset
);

  localparam logic [7:0] CODE_BREAK = 8'hF0;
  localparam logic [7:0] CODE_EXT   = 8'hE0;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_BREAK     = 2'd1,
    ST_EXT       = 2'd2,
    ST_EXT_BREAK = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic r_hold_left, r_hold_right, r_hold_jump, r_hold_reset;
  logic r_hold_ext_left, r_hold_ext_right, r_hold_ext_jump;

  logic w_hold_left_nxt, w_hold_right_nxt, w_hold_jump_nxt, w_hold_reset_nxt;
  logic w_hold_ext_left_nxt, w_hold_ext_right_nxt, w_hold_ext_jump_nxt;

  // A final byte either updates a non-extended flag or an extended flag, to w_upd_val.
  logic w_std_upd;
  logic w_ext_upd;
  logic w_upd_val;

  always_comb begin
    w_state_nxt = r_state;
    w_std_upd   = 1'b0;
    w_ext_upd   = 1'b0;
    w_upd_val   = 1'b0;
    if (key_valid) begin
      case (r_state)
        ST_IDLE: begin
          if (key_code == CODE_BREAK) begin
            w_state_nxt = ST_BREAK;
          end else if (key_code == CODE_EXT) begin
            w_state_nxt = ST_EXT;
          end else begin
            w_std_upd = 1'b1;
            w_upd_val = 1'b1;
          end
        end
        ST_BREAK: begin
          if (key_code == CODE_EXT) begin
            w_state_nxt = ST_EXT_BREAK;
          end else if (key_code != CODE_BREAK) begin
            w_std_upd   = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
        ST_EXT: begin
          if (key_code == CODE_BREAK) begin
            w_state_nxt = ST_EXT_BREAK;
          end else if (key_code != CODE_EXT) begin
            w_ext_upd   = 1'b1;
            w_upd_val   = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
        ST_EXT_BREAK: begin
          if ((key_code != CODE_EXT) && (key_code != CODE_BREAK)) begin
            w_ext_upd   = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Unmapped codes fall through every comparison and leave all flags untouched.
  always_comb begin
    w_hold_left_nxt      = r_hold_left;
    w_hold_right_nxt     = r_hold_right;
    w_hold_jump_nxt      = r_hold_jump;
    w_hold_reset_nxt     = r_hold_reset;
    w_hold_ext_left_nxt  = r_hold_ext_left;
    w_hold_ext_right_nxt = r_hold_ext_right;
    w_hold_ext_jump_nxt  = r_hold_ext_jump;
    if (w_std_upd) begin
      if (key_code == KEY_LEFT)  w_hold_left_nxt  = w_upd_val;
      if (key_code == KEY_RIGHT) w_hold_right_nxt = w_upd_val;
      if (key_code == KEY_JUMP)  w_hold_jump_nxt  = w_upd_val;
      if (key_code == KEY_RESET) w_hold_reset_nxt = w_upd_val;
    end
    if (w_ext_upd) begin
      if (key_code == EXT_LEFT)  w_hold_ext_left_nxt  = w_upd_val;
      if (key_code == EXT_RIGHT) w_hold_ext_right_nxt = w_upd_val;
      if (key_code == EXT_JUMP)  w_hold_ext_jump_nxt  = w_upd_val;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= ST_IDLE;
      r_hold_left      <= 1'b0;
      r_hold_right     <= 1'b0;
      r_hold_jump      <= 1'b0;
      r_hold_reset     <= 1'b0;
      r_hold_ext_left  <= 1'b0;
      r_hold_ext_right <= 1'b0;
      r_hold_ext_jump  <= 1'b0;
    end else begin
      r_state          <= w_state_nxt;
      r_hold_left      <= w_hold_left_nxt;
      r_hold_right     <= w_hold_right_nxt;
      r_hold_jump      <= w_hold_jump_nxt;
      r_hold_reset     <= w_hold_reset_nxt;
      r_hold_ext_left  <= w_hold_ext_left_nxt;
      r_hold_ext_right <= w_hold_ext_right_nxt;
      r_hold_ext_jump  <= w_hold_ext_jump_nxt;
    end
  end

  // Outputs lag the flags by one register stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      left  <= 1'b0;
      right <= 1'b0;
      jump  <= 1'b0;
      reset <= 1'b0;
    end else begin
      left  <= r_hold_left  | r_hold_ext_left;
      right <= r_hold_right | r_hold_ext_right;
      jump  <= r_hold_jump  | r_hold_ext_jump;
      reset <= r_hold_reset;
    end
  end

endmodule
